// File: rtl/ram_arbiter_if.sv
// Requester A/B handshakes and the single RAM port, grouped for the arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface ram_arbiter_if #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8
);
    logic                 a_req;
    logic                 a_we;
    logic [ADDR_SIZE-1:0] a_addr;
    logic [WORD_SIZE-1:0] a_wdata;
    logic                 a_ack;
    logic [WORD_SIZE-1:0] a_rdata;

    logic                 b_req;
    logic                 b_we;
    logic [ADDR_SIZE-1:0] b_addr;
    logic [WORD_SIZE-1:0] b_wdata;
    logic                 b_ack;
    logic [WORD_SIZE-1:0] b_rdata;

    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_wr;
    logic                 mem_cs;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_wdata, mem_wr, mem_cs,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_wdata, mem_wr, mem_cs,
        output mem_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter for a single-port async-read RAM; clears the RAM
// after reset, then serialises A/B requests as IDLE -> ACCESS -> RESP.
module ram_arbiter #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8,
    parameter int MEM_SIZE  = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         init_done,
    ram_arbiter_if.slave bus
);
    localparam int unsigned        LAST_WORD  = MEM_SIZE - 1;
    localparam logic [ADDR_SIZE:0] SWEEP_LAST = LAST_WORD[ADDR_SIZE:0];

    typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE:0]   sweep_cnt_q, sweep_cnt_d;
    logic                 init_done_q, init_done_d;
    logic                 last_grant_b_q, last_grant_b_d;
    logic                 grant_b_q, grant_b_d;
    logic                 grant_we_q, grant_we_d;
    logic                 a_ack_q, a_ack_d;
    logic                 b_ack_q, b_ack_d;
    logic [WORD_SIZE-1:0] a_rdata_q, a_rdata_d;
    logic [WORD_SIZE-1:0] b_rdata_q, b_rdata_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 mem_wr_q, mem_wr_d;
    logic                 mem_cs_q, mem_cs_d;
    logic                 win_b;

    // B wins when it is the only requester, or on a tie when A had the last tie.
    function automatic logic pick_b(input logic a_req, input logic b_req,
                                    input logic last_b);
        return b_req && (!a_req || !last_b);
    endfunction

    assign win_b = pick_b(bus.a_req, bus.b_req, last_grant_b_q);

    always_comb begin
        state_d        = state_q;
        sweep_cnt_d    = sweep_cnt_q;
        init_done_d    = init_done_q;
        last_grant_b_d = last_grant_b_q;
        grant_b_d      = grant_b_q;
        grant_we_d     = grant_we_q;
        a_ack_d        = 1'b0;
        b_ack_d        = 1'b0;
        a_rdata_d      = a_rdata_q;
        b_rdata_d      = b_rdata_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wr_d       = mem_wr_q;
        mem_cs_d       = mem_cs_q;

        case (state_q)
            INIT: begin
                mem_addr_d  = sweep_cnt_q[ADDR_SIZE-1:0];
                mem_wdata_d = '0;
                mem_wr_d    = 1'b1;
                mem_cs_d    = 1'b1;
                sweep_cnt_d = sweep_cnt_q + 1'b1;
                // The last word's write is still on the bus during the first IDLE cycle.
                if (sweep_cnt_q == SWEEP_LAST) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                mem_wr_d = 1'b0;
                mem_cs_d = 1'b0;
                if (bus.a_req && bus.b_req) begin
                    last_grant_b_d = win_b;
                end
                if (bus.a_req || bus.b_req) begin
                    grant_b_d   = win_b;
                    grant_we_d  = win_b ? bus.b_we    : bus.a_we;
                    mem_addr_d  = win_b ? bus.b_addr  : bus.a_addr;
                    mem_wdata_d = win_b ? bus.b_wdata : bus.a_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                mem_cs_d = 1'b1;
                mem_wr_d = grant_we_q;
                state_d  = RESP;
            end
            RESP: begin
                mem_wr_d = 1'b0;
                mem_cs_d = 1'b1;
                if (grant_b_q) begin
                    b_ack_d = 1'b1;
                    if (!grant_we_q) b_rdata_d = bus.mem_rdata;
                end else begin
                    a_ack_d = 1'b1;
                    if (!grant_we_q) a_rdata_d = bus.mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= INIT;
            sweep_cnt_q    <= '0;
            init_done_q    <= 1'b0;
            last_grant_b_q <= 1'b1;
            grant_b_q      <= 1'b0;
            grant_we_q     <= 1'b0;
            a_ack_q        <= 1'b0;
            b_ack_q        <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wr_q       <= 1'b0;
            mem_cs_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_cnt_q    <= sweep_cnt_d;
            init_done_q    <= init_done_d;
            last_grant_b_q <= last_grant_b_d;
            grant_b_q      <= grant_b_d;
            grant_we_q     <= grant_we_d;
            a_ack_q        <= a_ack_d;
            b_ack_q        <= b_ack_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wr_q       <= mem_wr_d;
            mem_cs_q       <= mem_cs_d;
        end
    end

    assign init_done     = init_done_q;
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_cs    = mem_cs_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, ack monitor and a scoreboard of expected
// acks (port, rdata) pushed at request time and popped as acks appear.
module tb_ram_arbiter;
    typedef struct packed {
        logic       port;   // 0 = A, 1 = B
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    logic preload = 1'b0;

    ram_arbiter_if #(.ADDR_SIZE(10), .WORD_SIZE(8)) bus ();

    ram_arbiter #(.ADDR_SIZE(10), .WORD_SIZE(8), .MEM_SIZE(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_done(init_done),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [1024];
    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'hC3;
        end else if (bus.mem_wr && bus.mem_cs) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q [$];
    ev_t        ack_log [$];
    logic [7:0] ref_mem [1024];
    logic [7:0] last_rd [2];
    int         wr_count = 0;
    logic [9:0] wr_addr = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.a_ack) ack_log.push_back({1'b0, bus.a_rdata});
            if (bus.b_ack) ack_log.push_back({1'b1, bus.b_rdata});
            if (init_done && bus.mem_wr && bus.mem_cs) begin
                wr_count++;
                wr_addr = bus.mem_addr;
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        exp_q.delete();
        ack_log.delete();
    endtask

    task automatic issue(input bit port, input bit we, input logic [9:0] addr,
                         input logic [7:0] wd, output int lat);
        ev_t e;
        int  n0;
        @(negedge clk); #1;
        e.port = port;
        if (we) begin
            e.data = last_rd[port];
            ref_mem[addr] = wd;
        end else begin
            e.data = ref_mem[addr];
            last_rd[port] = ref_mem[addr];
        end
        exp_q.push_back(e);
        n0 = ack_log.size();
        if (port) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end
        lat = 0;
        while (ack_log.size() == n0 && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
    endtask

    task automatic wait_init(output int cyc);
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 1100) begin
            @(negedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int         bad = 0;
        int         early = 0;
        int         lat;
        logic [9:0] ea;
        ev_t        got, exp;
        rst_n = 1'b0;
        preload = 1'b1;
        @(negedge clk);
        @(negedge clk);
        preload = 1'b0;
        #1;
        checks++;
        if ({init_done, bus.a_ack, bus.b_ack, bus.mem_wr, bus.mem_cs} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {init_done, bus.a_ack, bus.b_ack, bus.mem_wr, bus.mem_cs});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata} !== 34'b0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h a_rdata %h b_rdata %h required all 0",
                     bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk); #1;
            ea = 10'(k - 1);
            if (bus.mem_addr !== ea || bus.mem_wr !== 1'b1 || bus.mem_cs !== 1'b1 ||
                bus.mem_wdata !== 8'h00) bad++;
            if (k < 1024 && init_done !== 1'b0) early++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sweep_bus: %0d bad sweep cycles, required 0", bad);
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL sweep_early_done: init_done high on %0d cycles, required 0", early);
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done_rise: got %b required 1", init_done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.mem_wr !== 1'b0 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL post_sweep: mem_wr %b init_done %b required 0 1", bus.mem_wr, init_done);
        end
        issue(1'b0, 1'b0, 10'd517, 8'h00, lat);
        checks++;
        if (ack_log.size() == 0 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL read517: no ack, required A ack with 00");
        end else begin
            got = ack_log.pop_front();
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL read517: got port %0d data %h required port %0d data %h",
                         got.port, got.data, exp.port, exp.data);
            end
        end
    endtask

    task automatic test_write_read();
        int  lat;
        ev_t got, exp;
        exp_q.delete();
        ack_log.delete();
        wr_count = 0;
        issue(1'b0, 1'b1, 10'd10, 8'h14, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL wr10_latency: got %0d required 3", lat);
        end
        checks++;
        if (wr_count != 1 || wr_addr !== 10'd10) begin
            errors++;
            $display("FAIL wr10_strobe: %0d write cycles at addr %0d, required 1 at 10",
                     wr_count, wr_addr);
        end
        issue(1'b0, 1'b0, 10'd10, 8'h00, lat);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ack_log.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_rd10_ack%0d: no ack, required one", i);
            end else begin
                got = ack_log.pop_front();
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL wr_rd10_ack%0d: got port %0d data %h required port %0d data %h",
                             i, got.port, got.data, exp.port, exp.data);
                end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.a_rdata !== 8'h14) begin
            errors++;
            $display("FAIL a_rdata_hold: got %h required 14", bus.a_rdata);
        end
    endtask

    task automatic test_arbitration();
        int  guard = 0;
        ev_t got, exp;
        exp_q.delete();
        ack_log.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, last_rd[0]});
            ref_mem[5] = 8'hAA;
            exp_q.push_back({1'b1, ref_mem[5]});
            last_rd[1] = ref_mem[5];
        end
        @(negedge clk); #1;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 10'd5; bus.a_wdata = 8'hAA;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 10'd5; bus.b_wdata = 8'h00;
        while (ack_log.size() < 6 && guard < 60) begin
            @(negedge clk); #1;
            guard++;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ack_log.size() == 0) begin
                errors++;
                $display("FAIL grant%0d: no ack, required port %0d", i, i % 2);
            end else begin
                got = ack_log.pop_front();
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL grant%0d: got port %0d data %h required port %0d data %h",
                             i, got.port, got.data, exp.port, exp.data);
                end
            end
        end
        repeat (6) @(negedge clk);
        checks++;
        if (ack_log.size() != 0) begin
            errors++;
            $display("FAIL arb_extra_ack: %0d acks after release, required 0", ack_log.size());
        end
    endtask

    task automatic test_b_only();
        int  lat;
        int  a_seen = 0;
        ev_t got, exp;
        exp_q.delete();
        ack_log.delete();
        issue(1'b1, 1'b1, 10'd1023, 8'hFE, lat);
        issue(1'b1, 1'b0, 10'd1023, 8'h00, lat);
        repeat (3) @(negedge clk);
        for (int i = 0; i < ack_log.size(); i++) if (ack_log[i].port == 1'b0) a_seen++;
        checks++;
        if (a_seen != 0) begin
            errors++;
            $display("FAIL b_only_a_ack: %0d A acks, required 0", a_seen);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ack_log.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL b1023_ack%0d: no ack, required one", i);
            end else begin
                got = ack_log.pop_front();
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b1023_ack%0d: got port %0d data %h required port %0d data %h",
                             i, got.port, got.data, exp.port, exp.data);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int  cyc;
        int  lat;
        ev_t got, exp;
        exp_q.delete();
        ack_log.delete();
        @(negedge clk); #1;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 10'd3; bus.a_wdata = 8'h77;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.a_ack, bus.mem_wr, bus.mem_cs, init_done} !== 4'b0) begin
            errors++;
            $display("FAIL abort_outputs: ack/wr/cs/done %b required 0000",
                     {bus.a_ack, bus.mem_wr, bus.mem_cs, init_done});
        end
        @(negedge clk);
        bus.a_req = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.mem_addr !== 10'd0 || bus.mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL sweep_restart: addr %0d wr %b required 0 1", bus.mem_addr, bus.mem_wr);
        end
        wait_init(cyc);
        checks++;
        if (init_done !== 1'b1 || ack_log.size() != 0) begin
            errors++;
            $display("FAIL abort_no_ack: init_done %b acks %0d required 1 0",
                     init_done, ack_log.size());
        end
        issue(1'b0, 1'b0, 10'd3, 8'h00, lat);
        checks++;
        if (ack_log.size() == 0 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL read3_after_abort: no ack, required A ack with 00");
        end else begin
            got = ack_log.pop_front();
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL read3_after_abort: got port %0d data %h required port %0d data %h",
                         got.port, got.data, exp.port, exp.data);
            end
        end
    endtask

    task automatic test_init_requests();
        int  cyc;
        int  lat = 0;
        ev_t got, exp;
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 10'd7; bus.a_wdata = 8'h00;
        exp_q.push_back({1'b0, ref_mem[7]});
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc);
        checks++;
        if (init_done !== 1'b1 || ack_log.size() != 0) begin
            errors++;
            $display("FAIL init_req_early: init_done %b acks %0d required 1 0",
                     init_done, ack_log.size());
        end
        while (ack_log.size() == 0 && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
        bus.a_req = 1'b0;
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL init_req_latency: got %0d cycles required 3", lat);
        end
        checks++;
        if (ack_log.size() == 0) begin
            errors++;
            $display("FAIL init_req_ack: no ack, required A ack with 00");
        end else begin
            got = ack_log.pop_front();
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL init_req_ack: got port %0d data %h required port %0d data %h",
                         got.port, got.data, exp.port, exp.data);
            end
        end
    endtask

    initial begin
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        test_reset();
        test_write_read();
        test_arbitration();
        test_b_only();
        test_reset_mid_access();
        test_init_requests();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
